// File: rtl/mips_pkg.sv
// Shared constants for the Phase 2 MIPS datapath: default widths, MEM/WB payload
// width and the skid-buffer occupancy encoding.
package mips_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_CNT_W  = 32;

    // {mem_to_reg, reg_write, wr_addr, alu_result, mem_data}
    function automatic int unsigned payload_w(input int unsigned addr_w,
                                              input int unsigned data_w);
        return 2 + addr_w + 2 * data_w;
    endfunction

    localparam int unsigned PAYLOAD_W = payload_w(DEF_ADDR_W, DEF_DATA_W);

    // Occupancy encoded as {skid_valid, main_valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer. in_ready comes straight from a flop, so the
// downstream ready never reaches the upstream combinationally.
module skid_buffer
    import mips_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = mips_pkg::PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic                 m_valid_q, m_valid_d;
    logic                 s_valid_q, s_valid_d;
    logic [PAYLOAD_W-1:0] m_data_q, m_data_d;
    logic [PAYLOAD_W-1:0] s_data_q;
    logic                 m_load, s_load;
    logic                 accept, fire;
    logic [1:0]           state;

    assign state     = {s_valid_q, m_valid_q};
    assign in_ready  = ~s_valid_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign accept    = in_valid & in_ready;
    assign fire      = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = in_data;
        m_load    = 1'b0;
        s_load    = 1'b0;
        if (flush) begin
            // Offered input is dropped; a concurrent fire is still seen downstream.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_load    = 1'b1;
                        m_valid_d = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && fire) begin
                        m_load = 1'b1;
                    end else if (accept) begin
                        s_load    = 1'b1;
                        s_valid_d = 1'b1;
                    end else if (fire) begin
                        m_valid_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (fire) begin
                        m_load    = 1'b1;
                        m_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                    end
                end
                default: begin
                    // Skid valid without main valid is unreachable; recover to empty.
                    m_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            if (m_load) begin
                m_data_q <= m_data_d;
            end
            if (s_load) begin
                s_data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: buffers memory-stage results in a skid buffer, drives the
// writeback mux and register-file write port, and counts retired instructions.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = mips_pkg::DEF_DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::DEF_ADDR_W,
    parameter int unsigned CNT_W  = mips_pkg::DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_wr_addr,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sel,
    output logic [DATA_W-1:0] int0,
    output logic [DATA_W-1:0] int1,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              reg_write,
    output logic [CNT_W-1:0]  retired
);

    localparam int unsigned PW = payload_w(ADDR_W, DATA_W);

    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    out_payload;
    logic             main_reg_write;
    logic [CNT_W-1:0] retired_q;

    assign in_payload = {in_mem_to_reg, in_reg_write, in_wr_addr, in_alu_result, in_mem_data};

    skid_buffer #(
        .PAYLOAD_W (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {sel, main_reg_write, wr_addr, int0, int1} = out_payload;

    // Stale payloads stay on the mux lines; only the write enable is qualified.
    assign reg_write = main_reg_write & out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (out_valid && out_ready) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage built with a 4-bit retired counter.
module tb_mem_wb_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_mem_to_reg;
    logic          in_reg_write;
    logic [AW-1:0] in_wr_addr;
    logic [DW-1:0] in_alu_result;
    logic [DW-1:0] in_mem_data;
    logic          out_valid;
    logic          out_ready;
    logic          sel;
    logic [DW-1:0] int0;
    logic [DW-1:0] int1;
    logic [AW-1:0] wr_addr;
    logic          reg_write;
    logic [CW-1:0] retired;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .CNT_W  (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mem_to_reg (in_mem_to_reg),
        .in_reg_write  (in_reg_write),
        .in_wr_addr    (in_wr_addr),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sel           (sel),
        .int0          (int0),
        .int1          (int1),
        .wr_addr       (wr_addr),
        .reg_write     (reg_write),
        .retired       (retired)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mtr, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] alu, input logic [DW-1:0] mem);
        in_valid      = 1'b1;
        in_mem_to_reg = mtr;
        in_reg_write  = rw;
        in_wr_addr    = addr;
        in_alu_result = alu;
        in_mem_data   = mem;
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_mem_to_reg = 1'b0;
        in_reg_write  = 1'b0;
        in_wr_addr    = '0;
        in_alu_result = '0;
        in_mem_data   = '0;
        out_ready     = 1'b1;

        // Reset values
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_reg_write", 64'(reg_write), 64'(0));
        chk("rst_sel",       64'(sel),       64'(0));
        chk("rst_int0",      64'(int0),      64'(0));
        chk("rst_int1",      64'(int1),      64'(0));
        chk("rst_wr_addr",   64'(wr_addr),   64'(0));
        chk("rst_retired",   64'(retired),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single entry, latency 1, retired the cycle after
        drive(1'b1, 1'b1, 5'd5, 32'h10, 32'hDEADBEEF);
        tick();
        in_valid = 1'b0;
        chk("one_out_valid", 64'(out_valid), 64'(1));
        chk("one_sel",       64'(sel),       64'(1));
        chk("one_int0",      64'(int0),      64'h10);
        chk("one_int1",      64'(int1),      64'hDEADBEEF);
        chk("one_wr_addr",   64'(wr_addr),   64'(5));
        chk("one_reg_write", 64'(reg_write), 64'(1));
        tick();
        chk("one_retired",   64'(retired),   64'(1));
        chk("one_drain_vld", 64'(out_valid), 64'(0));
        chk("one_drain_rw",  64'(reg_write), 64'(0));
        chk("one_hold_int1", 64'(int1),      64'hDEADBEEF);

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            drive(1'(i), 1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(i));
            tick();
            chk("str_out_valid", 64'(out_valid), 64'(1));
            chk("str_in_ready",  64'(in_ready),  64'(1));
            chk("str_int0",      64'(int0),      64'h100 + 64'(i));
            chk("str_int1",      64'(int1),      64'h200 + 64'(i));
            chk("str_wr_addr",   64'(wr_addr),   64'(i + 1));
            chk("str_sel",       64'(sel),       64'(i % 2));
        end
        in_valid = 1'b0;
        tick();
        chk("str_drain_vld", 64'(out_valid), 64'(0));
        chk("str_retired",   64'(retired),   64'(9));

        // Stall with three entries offered
        out_ready = 1'b0;
        drive(1'b0, 1'b1, 5'd11, 32'hB1, 32'h0);
        tick();
        chk("stl_rdy1",  64'(in_ready), 64'(1));
        chk("stl_vld1",  64'(out_valid), 64'(1));
        chk("stl_m1",    64'(int0),     64'hB1);
        drive(1'b0, 1'b1, 5'd12, 32'hB2, 32'h0);
        tick();
        chk("stl_rdy2",  64'(in_ready), 64'(0));
        chk("stl_m2",    64'(int0),     64'hB1);
        drive(1'b0, 1'b1, 5'd13, 32'hB3, 32'h0);
        tick();
        chk("stl_rdy3",  64'(in_ready), 64'(0));
        chk("stl_m3",    64'(int0),     64'hB1);
        out_ready = 1'b1;
        tick();
        chk("stl_out2",  64'(int0),     64'hB2);
        chk("stl_addr2", 64'(wr_addr),  64'(12));
        chk("stl_rdy4",  64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        chk("stl_out3",  64'(int0),     64'hB3);
        chk("stl_vld3",  64'(out_valid), 64'(1));
        tick();
        chk("stl_drain", 64'(out_valid), 64'(0));
        chk("stl_ret",   64'(retired),  64'(12));

        // Flush while FULL with an entry offered
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd21, 32'hC1, 32'hC1C1);
        tick();
        drive(1'b1, 1'b1, 5'd22, 32'hC2, 32'hC2C2);
        tick();
        chk("fl_full_rdy", 64'(in_ready), 64'(0));
        drive(1'b1, 1'b1, 5'd23, 32'hC3, 32'hC3C3);
        flush = 1'b1;
        tick();
        chk("fl_vld",  64'(out_valid), 64'(0));
        chk("fl_rw",   64'(reg_write), 64'(0));
        chk("fl_rdy",  64'(in_ready),  64'(1));
        chk("fl_ret",  64'(retired),   64'(12));
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_no_c3", 64'(out_valid), 64'(0));

        // Flush coinciding with a fire still retires; offered input dropped
        out_ready = 1'b0;
        drive(1'b0, 1'b1, 5'd24, 32'hD1, 32'h0);
        tick();
        drive(1'b0, 1'b1, 5'd25, 32'hD2, 32'h0);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("flf_vld", 64'(out_valid), 64'(0));
        chk("flf_ret", 64'(retired),   64'(13));
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("flf_no_d2", 64'(out_valid), 64'(0));

        // Counter wrap (4-bit)
        drive(1'b0, 1'b0, 5'd1, 32'hE0, 32'h0);
        tick();
        chk("wr_rw_off", 64'(reg_write), 64'(0));
        drive(1'b0, 1'b0, 5'd2, 32'hE1, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_15", 64'(retired), 64'(15));
        drive(1'b0, 1'b0, 5'd3, 32'hE2, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_0",  64'(retired), 64'(0));

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd7, 32'hF1, 32'hF1F1);
        tick();
        drive(1'b1, 1'b1, 5'd8, 32'hF2, 32'hF2F2);
        tick();
        chk("ar_full_rdy", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld",  64'(out_valid), 64'(0));
        chk("ar_rdy",  64'(in_ready),  64'(1));
        chk("ar_rw",   64'(reg_write), 64'(0));
        chk("ar_int0", 64'(int0),      64'(0));
        chk("ar_int1", 64'(int1),      64'(0));
        chk("ar_sel",  64'(sel),       64'(0));
        chk("ar_ret",  64'(retired),   64'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b1, 5'd9, 32'h99, 32'h9999);
        tick();
        in_valid = 1'b0;
        chk("ar_new_vld",  64'(out_valid), 64'(1));
        chk("ar_new_int0", 64'(int0),      64'h99);
        chk("ar_new_addr", 64'(wr_addr),   64'(9));
        chk("ar_new_ret0", 64'(retired),   64'(0));
        tick();
        chk("ar_new_ret1", 64'(retired),   64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
